wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-requester write-back arbiter feeding one register-file write port.
// Define WB_ROUND_ROBIN_EN for round-robin tie-break (default: requester 0 wins ties).
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_dst,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_dst,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_wrt_en,
  output logic [ADDR_W-1:0] rf_dst,
  output logic [DATA_W-1:0] rf_dst_data,
  input  logic [ADDR_W-1:0] chk_reg,
  output logic              chk_pending,
  output logic [15:0]       conflict_cnt
);

  logic [1:0]             v_q, v_d;
  logic [1:0]             age_q, age_d;
  logic [1:0][ADDR_W-1:0] dst_q, dst_d;
  logic [1:0][DATA_W-1:0] dat_q, dat_d;
  logic [15:0]            cnt_q, cnt_d;

  logic [1:0] gnt, rdy, acc, held, vld;
  logic       both, tie, tie_w1;

`ifdef WB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Pointer names the requester that won the previous tie.
  assign tie_w1 = ~last_q;
  assign last_d = tie ? gnt[1] : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  assign tie_w1 = 1'b0;
`endif

  assign vld = {req1_valid, req0_valid};

  always_comb begin
    both = v_q[0] & v_q[1];
    tie  = both & (age_q[0] == age_q[1]);
    gnt  = 2'b00;
    unique case (1'b1)
      tie:           gnt = tie_w1 ? 2'b10 : 2'b01;
      both & ~tie:   gnt = age_q[0] ? 2'b10 : 2'b01;
      default:       gnt = v_q;
    endcase
    rdy  = ~v_q | gnt;
    acc  = vld & rdy;
    held = v_q & ~gnt;
  end

  // age=1 marks the younger entry; it clears once the other side drains.
  always_comb begin
    v_d   = held | acc;
    dst_d = dst_q;
    dat_d = dat_q;
    age_d = 2'b00;
    if (acc[0]) begin
      dst_d[0] = req0_dst;
      dat_d[0] = req0_data;
    end
    if (acc[1]) begin
      dst_d[1] = req1_dst;
      dat_d[1] = req1_data;
    end
    age_d[0] = acc[0] ? held[1] : (held[0] & age_q[0] & held[1]);
    age_d[1] = acc[1] ? held[0] : (held[1] & age_q[1] & held[0]);
    cnt_d    = cnt_q;
    if (both && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      age_q <= '0;
      dst_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      age_q <= age_d;
      dst_q <= dst_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign req0_ready   = rdy[0];
  assign req1_ready   = rdy[1];
  assign rf_wrt_en    = |gnt;
  assign rf_dst       = ({ADDR_W{gnt[0]}} & dst_q[0])
                      | ({ADDR_W{gnt[1]}} & dst_q[1]);
  assign rf_dst_data  = ({DATA_W{gnt[0]}} & dat_q[0])
                      | ({DATA_W{gnt[1]}} & dat_q[1]);
  assign chk_pending  = (v_q[0] & (dst_q[0] == chk_reg))
                      | (v_q[1] & (dst_q[1] == chk_reg));
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter with a timestamp-based reference model.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_dst = '0, req1_dst = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        rf_wrt_en;
  logic [3:0]  rf_dst;
  logic [31:0] rf_dst_data;
  logic [3:0]  chk_reg = '0;
  logic        chk_pending;
  logic [15:0] conflict_cnt;

  wb_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dst(req0_dst), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dst(req1_dst), .req1_data(req1_data),
    .rf_wrt_en(rf_wrt_en), .rf_dst(rf_dst), .rf_dst_data(rf_dst_data),
    .chk_reg(chk_reg), .chk_pending(chk_pending),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic [31:0] x;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_v[2];
  logic [3:0]  m_dst[2];
  logic [31:0] m_dat[2];
  int          m_st[2];
  bit          m_last;
  int          m_cnt;
  int          ecnt = 0;
  wr_t         wlog[$];
  bit          rdy_drop[2];

  // One clock: drive at posedge+1, check at negedge, advance model.
  task automatic step(input logic v0, input logic [3:0] d0, input logic [31:0] x0,
                      input logic v1, input logic [3:0] d1, input logic [31:0] x1,
                      input logic [3:0] chk);
    int          g;
    bit          tie;
    bit [1:0]    er;
    logic        ep;
    logic [3:0]  edst;
    logic [31:0] edat;
    req0_valid = v0; req0_dst = d0; req0_data = x0;
    req1_valid = v1; req1_dst = d1; req1_data = x1;
    chk_reg = chk;
    tie = m_v[0] && m_v[1] && (m_st[0] == m_st[1]);
    g = -1;
    if (m_v[0] && m_v[1]) begin
      if (tie) begin
`ifdef WB_ROUND_ROBIN_EN
        g = m_last ? 0 : 1;
`else
        g = 0;
`endif
      end else begin
        g = (m_st[0] < m_st[1]) ? 0 : 1;
      end
    end else if (m_v[0]) g = 0;
    else if (m_v[1]) g = 1;
    er[0] = !m_v[0] || g == 0;
    er[1] = !m_v[1] || g == 1;
    ep = (m_v[0] && m_dst[0] == chk) || (m_v[1] && m_dst[1] == chk);
    edst = '0;
    edat = '0;
    if (g >= 0) begin
      edst = m_dst[g];
      edat = m_dat[g];
    end
    @(negedge clk);
    n_cmp++;
    if (rf_wrt_en !== (g >= 0)) begin
      n_bad++;
      $display("FAIL step_wrt_en t=%0t got %b want %b", $time, rf_wrt_en, g >= 0);
    end
    n_cmp++;
    if (rf_dst !== edst || rf_dst_data !== edat) begin
      n_bad++;
      $display("FAIL step_rf t=%0t got %0d/%h want %0d/%h",
               $time, rf_dst, rf_dst_data, edst, edat);
    end
    n_cmp++;
    if ({req1_ready, req0_ready} !== er) begin
      n_bad++;
      $display("FAIL step_ready t=%0t got %b want %b", $time,
               {req1_ready, req0_ready}, er);
    end
    n_cmp++;
    if (chk_pending !== ep) begin
      n_bad++;
      $display("FAIL step_pending t=%0t got %b want %b", $time, chk_pending, ep);
    end
    n_cmp++;
    if (conflict_cnt !== m_cnt[15:0]) begin
      n_bad++;
      $display("FAIL step_cnt t=%0t got %0d want %0d", $time, conflict_cnt, m_cnt);
    end
    if (rf_wrt_en) wlog.push_back('{rf_dst, rf_dst_data});
    if (!req0_ready) rdy_drop[0] = 1'b1;
    if (!req1_ready) rdy_drop[1] = 1'b1;
    if (m_v[0] && m_v[1] && m_cnt < 65535) m_cnt++;
    if (tie) m_last = (g == 1);
    if (g >= 0) m_v[g] = 1'b0;
    if (v0 && er[0]) begin
      m_v[0] = 1'b1; m_dst[0] = d0; m_dat[0] = x0; m_st[0] = ecnt;
    end
    if (v1 && er[1]) begin
      m_v[1] = 1'b1; m_dst[1] = d1; m_dat[1] = x1; m_st[1] = ecnt;
    end
    ecnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] chk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, chk);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk_reg = 4'd7;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_cmp++;
      if (rf_wrt_en !== 1'b0 || rf_dst !== 4'd0 || rf_dst_data !== 32'd0) begin
        n_bad++;
        $display("FAIL rst_rf got %b/%0d/%h want 0/0/0", rf_wrt_en, rf_dst, rf_dst_data);
      end
      n_cmp++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rst_ready got %b%b want 11", req1_ready, req0_ready);
      end
      n_cmp++;
      if (chk_pending !== 1'b0 || conflict_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL rst_pend_cnt got %b/%0d want 0/0", chk_pending, conflict_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_v = '{0, 0};
    m_last = 1'b1;
    m_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    apply_reset();
    idle(2, 4'd7);
  endtask

  task automatic test_single;
    wlog.delete();
    rdy_drop = '{0, 0};
    step(1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 4'd3);
    n_cmp++;
    if (rf_wrt_en !== 1'b1 || rf_dst !== 4'd3 || rf_dst_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL single_out got %b/%0d/%h want 1/3/deadbeef",
               rf_wrt_en, rf_dst, rf_dst_data);
    end
    idle(2, 4'd3);
    n_cmp++;
    if (wlog.size() != 1 || rdy_drop[0]) begin
      n_bad++;
      $display("FAIL single_log got %0d writes drop=%b want 1 writes drop=0",
               wlog.size(), rdy_drop[0]);
    end
  endtask

  task automatic test_stream;
    wlog.delete();
    rdy_drop = '{0, 0};
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'(i + 8), 32'(i + 1), 4'd0);
    idle(2, 4'd0);
    n_cmp++;
    if (wlog.size() != 4 || rdy_drop[1]) begin
      n_bad++;
      $display("FAIL stream_len got %0d drop=%b want 4 drop=0", wlog.size(), rdy_drop[1]);
    end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      n_cmp++;
      if (wlog[i].x !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL stream_order[%0d] got %h want %h", i, wlog[i].x, i + 1);
      end
    end
  endtask

  task automatic test_tie;
    logic [31:0] first;
    apply_reset();
    wlog.delete();
    step(1, 4'd5, 32'hA, 1, 4'd5, 32'hB, 4'd5);
    idle(3, 4'd5);
    n_cmp++;
    if (wlog.size() != 2 || wlog[0].x !== 32'hA || wlog[1].x !== 32'hB
        || conflict_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL tie1 got n=%0d cnt=%0d want A,B cnt=1", wlog.size(), conflict_cnt);
    end
    wlog.delete();
    step(1, 4'd5, 32'hA, 1, 4'd5, 32'hB, 4'd5);
    idle(3, 4'd5);
`ifdef WB_ROUND_ROBIN_EN
    first = 32'hB;
`else
    first = 32'hA;
`endif
    n_cmp++;
    if (wlog.size() != 2 || wlog[0].x !== first || conflict_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL tie2 got n=%0d cnt=%0d want first=%h cnt=2",
               wlog.size(), conflict_cnt, first);
    end
  endtask

  task automatic test_age;
    apply_reset();
    wlog.delete();
    step(1, 4'd1, 32'h100, 1, 4'd2, 32'h200, 4'd0);
    step(1, 4'd3, 32'h300, 0, 0, 0, 4'd0);
    idle(3, 4'd0);
    n_cmp++;
    if (wlog.size() != 3 || wlog[0].x !== 32'h100 || wlog[1].x !== 32'h200
        || wlog[2].x !== 32'h300) begin
      n_bad++;
      $display("FAIL age_order got n=%0d want 100,200,300", wlog.size());
    end
  endtask

  task automatic test_hazard_reset;
    step(1, 4'd7, 32'h70, 1, 4'd7, 32'h71, 4'd7);
    step(0, 0, 0, 0, 0, 0, 4'd7);
    n_cmp++;
    if (chk_pending !== 1'b1) begin
      n_bad++;
      $display("FAIL hazard_pending got %b want 1", chk_pending);
    end
    apply_reset();
    idle(2, 4'd7);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 3)));
    idle(3, 4'd0);
  endtask

  task automatic test_saturate;
    apply_reset();
    for (int i = 0; i < 65540; i++)
      step(1, 4'd1, $urandom, 1, 4'd2, $urandom, 4'd0);
    n_cmp++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_reach got %h want ffff", conflict_cnt);
    end
    for (int i = 0; i < 3; i++) step(1, 4'd1, $urandom, 1, 4'd2, $urandom, 4'd0);
    n_cmp++;
    if (conflict_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_hold got %h want ffff", conflict_cnt);
    end
    apply_reset();
    idle(1, 4'd0);
  endtask

  initial begin
    m_v = '{0, 0};
    m_last = 1'b1;
    m_cnt = 0;
    test_reset();
    test_single();
    test_stream();
    test_tie();
    test_age();
    test_hazard_reset();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
